// File: rtl/ram_arbiter.sv
// Round-robin two-master arbiter for a single-port synchronous RAM, with a
// per-master lock for atomic read-modify-write sequences bounded by a hold timeout.
module ram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int BE_W     = DATA_W / 8,
    parameter int HOLD_MAX = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic             rr_last_q, rr_last_d;
    logic             lock_vld_q, lock_vld_d;
    logic             lock_own_q, lock_own_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       bar_q, bar_d;
    logic             rdv_vld_q, rdv_vld_d;
    logic             rdv_own_q, rdv_own_d;

    logic req0, req1;
    logic gnt_vld, gnt_idx, gnt_wr, gnt_lock;
    logic own_lock, timeout, release_lock;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // A held lock reserves the RAM for its owner even while the owner is idle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (lock_vld_q) begin
            gnt_idx = lock_own_q;
            gnt_vld = lock_own_q ? req1 : req0;
        end else if (req0 && req1) begin
            gnt_vld = 1'b1;
            gnt_idx = ~rr_last_q;
        end else if (req0) begin
            gnt_vld = 1'b1;
        end else if (req1) begin
            gnt_vld = 1'b1;
            gnt_idx = 1'b1;
        end
        if (!reset_n) begin
            gnt_vld = 1'b0;
        end
    end

    assign gnt_wr       = gnt_idx ? m1_write : m0_write;
    assign gnt_lock     = gnt_idx ? m1_lock : m0_lock;
    assign own_lock     = lock_own_q ? m1_lock : m0_lock;
    assign timeout      = lock_vld_q && (hold_cnt_q == CNT_W'(HOLD_MAX));
    assign release_lock = lock_vld_q && (!own_lock || timeout);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q  <= 1'b1;
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
            hold_cnt_q <= '0;
            bar_q      <= '0;
            rdv_vld_q  <= 1'b0;
            rdv_own_q  <= 1'b0;
        end else begin
            rr_last_q  <= rr_last_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            hold_cnt_q <= hold_cnt_d;
            bar_q      <= bar_d;
            rdv_vld_q  <= rdv_vld_d;
            rdv_own_q  <= rdv_own_d;
        end
    end

    always_comb begin
        rr_last_d  = rr_last_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        hold_cnt_d = hold_cnt_q;
        bar_d      = bar_q;
        if (gnt_vld) begin
            rr_last_d = gnt_idx;
        end
        // A timed-out owner stays barred until the other side is served or goes quiet.
        if (!req1 || (gnt_vld && gnt_idx)) begin
            bar_d[0] = 1'b0;
        end
        if (!req0 || (gnt_vld && !gnt_idx)) begin
            bar_d[1] = 1'b0;
        end
        if (release_lock) begin
            lock_vld_d = 1'b0;
            hold_cnt_d = '0;
            rr_last_d  = lock_own_q;
            if (timeout) begin
                bar_d[lock_own_q] = 1'b1;
            end
        end else if (lock_vld_q) begin
            if (hold_cnt_q < CNT_W'(HOLD_MAX)) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end else if (gnt_vld && gnt_lock && !bar_q[gnt_idx]) begin
            lock_vld_d = 1'b1;
            lock_own_d = gnt_idx;
            hold_cnt_d = CNT_W'(1);
        end
        rdv_vld_d = gnt_vld && !gnt_wr;
        rdv_own_d = gnt_idx;
    end

    always_comb begin
        ram_chipselect   = gnt_vld;
        ram_write        = gnt_vld && gnt_wr;
        ram_address      = gnt_idx ? m1_address : m0_address;
        ram_byteenable   = gnt_idx ? m1_byteenable : m0_byteenable;
        ram_writedata    = gnt_idx ? m1_writedata : m0_writedata;
        m0_waitrequest   = !(gnt_vld && !gnt_idx);
        m1_waitrequest   = !(gnt_vld && gnt_idx);
        m0_readdatavalid = rdv_vld_q && !rdv_own_q;
        m1_readdatavalid = rdv_vld_q && rdv_own_q;
        m0_readdata      = m0_readdatavalid ? ram_readdata : '0;
        m1_readdata      = m1_readdatavalid ? ram_readdata : '0;
    end

    assign ram_clken = 1'b1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural write-first RAM plus
// hand-computed expectations for grants, read returns, locking and reset.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  m0_address, m1_address, ram_address;
    logic [3:0]  m0_byteenable, m1_byteenable, ram_byteenable;
    logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [31:0] m0_writedata, m1_writedata, ram_writedata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata, ram_readdata;
    logic        ram_chipselect, ram_write, ram_clken;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
    );

    // Write-first single-port RAM with byte lanes and one-cycle read latency
    logic [31:0] mem [0:1023];
    logic [31:0] ram_merge;

    always_comb begin
        ram_merge = mem[ram_address];
        for (int b = 0; b < 4; b++) begin
            if (ram_byteenable[b]) ram_merge[8*b +: 8] = ram_writedata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                mem[ram_address] <= ram_merge;
                ram_readdata     <= ram_merge;
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_lock = 0;
        m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_lock = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        reset_n = 0;
        idle();
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic wr(input int m, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        tick();
        idle();
        if (m == 0) begin
            m0_write = 1; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_write = 1; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
        smp();
        check("wr_wait", (m == 0) ? m0_waitrequest : m1_waitrequest, 0);
        check("wr_ramwrite", ram_write, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp0;
        reset_n = 0;
        idle();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        m0_read = 1;
        m1_read = 1;
        smp();
        check("rst_wait0", m0_waitrequest, 1);
        check("rst_wait1", m1_waitrequest, 1);
        check("rst_cs", ram_chipselect, 0);
        check("rst_rdv0", m0_readdatavalid, 0);
        check("rst_rd0", m0_readdata, 0);
        idle();
        @(negedge clk);
        reset_n = 1;

        wr(0, 10'd1, 32'h1111_0001, 4'hF);
        wr(1, 10'd2, 32'h2222_0002, 4'hF);
        wr(0, 10'd9, 32'h0000_0009, 4'hF);

        // Single-master write then read-back
        wr(0, 10'd5, 32'hDEAD_BEEF, 4'hF);
        tick(); idle(); m0_read = 1; m0_address = 10'd5;
        smp();
        check("t1_rd_wait", m0_waitrequest, 0);
        check("t1_wr_no_rdv", m0_readdatavalid, 0);
        tick(); idle();
        smp();
        check("t1_rdv0", m0_readdatavalid, 1);
        check("t1_rd0", m0_readdata, 32'hDEAD_BEEF);
        check("t1_rdv1", m1_readdatavalid, 0);
        check("t1_rd1", m1_readdata, 0);
        tick();
        smp();
        check("t1_rdv0_once", m0_readdatavalid, 0);

        // Round-robin alternation with back-to-back reads
        do_reset();
        for (int k = 0; k < 7; k++) begin
            tick();
            idle();
            if (k < 6) begin
                m0_read = 1; m0_address = 10'd1;
                m1_read = 1; m1_address = 10'd2;
            end
            smp();
            if (k < 6) begin
                check("t2_wait0", m0_waitrequest, k[0]);
                check("t2_wait1", m1_waitrequest, !k[0]);
            end
            if (k >= 1) begin
                exp0 = ((k - 1) % 2 == 0);
                check("t2_rdv0", m0_readdatavalid, exp0);
                check("t2_rdv1", m1_readdatavalid, !exp0);
                check("t2_rd0", m0_readdata, exp0 ? 32'h1111_0001 : 32'h0);
                check("t2_rd1", m1_readdata, exp0 ? 32'h0 : 32'h2222_0002);
            end
        end

        // Partial byte-lane write
        wr(1, 10'd7, 32'h1122_3344, 4'hF);
        wr(1, 10'd7, 32'h00AB_0000, 4'b0100);
        tick(); idle(); m1_read = 1; m1_address = 10'd7;
        smp();
        tick(); idle();
        smp();
        check("t3_rdv1", m1_readdatavalid, 1);
        check("t3_rd1", m1_readdata, 32'h11AB_3344);

        // Locked read-modify-write with an idle cycle inside the lock
        do_reset();
        tick();
        m0_read = 1; m0_address = 10'd9; m0_lock = 1;
        m1_read = 1; m1_address = 10'd2;
        smp();
        check("t4_c0_wait0", m0_waitrequest, 0);
        check("t4_c0_wait1", m1_waitrequest, 1);
        tick(); m0_read = 0;
        smp();
        check("t4_idle_wait1", m1_waitrequest, 1);
        check("t4_idle_cs", ram_chipselect, 0);
        check("t4_rdv0", m0_readdatavalid, 1);
        check("t4_rd0", m0_readdata, 32'h0000_0009);
        tick(); m0_write = 1; m0_writedata = 32'h0000_000A; m0_byteenable = 4'hF;
        smp();
        check("t4_wr_wait0", m0_waitrequest, 0);
        check("t4_wr_wait1", m1_waitrequest, 1);
        tick(); m0_write = 0; m0_lock = 0;
        smp();
        check("t4_drop_wait1", m1_waitrequest, 1);
        tick();
        smp();
        check("t4_m1_wait", m1_waitrequest, 0);
        check("t4_m1_addr", 32'(ram_address), 32'd2);
        tick(); m1_read = 0;
        smp();
        check("t4_rdv1", m1_readdatavalid, 1);
        check("t4_rd1", m1_readdata, 32'h2222_0002);
        tick(); idle(); m0_read = 1; m0_address = 10'd9;
        smp();
        tick(); idle();
        smp();
        check("t4_rmw_result", m0_readdata, 32'h0000_000A);

        // Lock timeout with the other master waiting
        do_reset();
        tick();
        m0_read = 1; m0_address = 10'd1; m0_lock = 1;
        m1_read = 1; m1_address = 10'd2;
        smp();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                tick();
                smp();
            end
            check("t5_hold_wait0", m0_waitrequest, 0);
            check("t5_hold_wait1", m1_waitrequest, 1);
        end
        tick();
        smp();
        check("t5_to_wait1", m1_waitrequest, 0);
        check("t5_to_wait0", m0_waitrequest, 1);
        tick();
        smp();
        check("t5_regain_wait0", m0_waitrequest, 0);
        tick(); m0_lock = 0;
        smp();
        check("t5_relock_wait1", m1_waitrequest, 1);
        tick();
        smp();
        check("t5_after_wait1", m1_waitrequest, 0);

        // Timed-out owner served alone must not silently re-lock
        do_reset();
        tick(); idle();
        m0_read = 1; m0_address = 10'd1; m0_lock = 1;
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) tick();
            smp();
            check("t5b_solo_wait0", m0_waitrequest, 0);
        end
        tick(); m1_read = 1; m1_address = 10'd2;
        smp();
        check("t5b_barred_wait1", m1_waitrequest, 0);

        // Asynchronous reset right after a read grant
        do_reset();
        tick(); m0_read = 1; m0_address = 10'd5;
        smp();
        check("t6_grant", m0_waitrequest, 0);
        tick();
        reset_n = 0;
        m1_read = 1; m1_address = 10'd2;
        #1;
        check("t6_rdv0", m0_readdatavalid, 0);
        check("t6_rd0", m0_readdata, 0);
        check("t6_wait0", m0_waitrequest, 1);
        check("t6_wait1", m1_waitrequest, 1);
        check("t6_cs", ram_chipselect, 0);
        smp();
        idle();
        #1;
        reset_n = 1;
        tick();
        m0_read = 1; m0_address = 10'd1;
        m1_read = 1; m1_address = 10'd2;
        smp();
        check("t6_first_wait0", m0_waitrequest, 0);
        check("t6_first_wait1", m1_waitrequest, 1);
        tick(); idle();
        smp();
        check("t6_post_rdv0", m0_readdatavalid, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-master arbiter sharing the single-port 1024x32 on-chip RAM (synchronous read, one-cycle read latency, byte enables). It sits between the RAM's Avalon slave port and two requesters, e.g. the lock FSM and the host CPU.
- Grants one access per cycle, round-robin.
- Supports a per-master lock for atomic read-modify-write sequences, bounded by a hold timeout.
- Returns read data to the issuing master with readdatavalid.

Parameters:
ADDR_W, 10, word address width
DATA_W, 32, data width
BE_W, 4, byte-enable width (DATA_W/8)
HOLD_MAX, 16, maximum cycles a lock may keep the RAM reserved; must be >= 2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mX_address  in  ADDR_W  word address, X = 0,1
mX_byteenable  in  BE_W  byte lanes for writes
mX_read  in  1  read request
mX_write  in  1  write request
mX_writedata  in  DATA_W  write data
mX_lock  in  1  request/keep exclusive ownership
mX_waitrequest  out  1  request not accepted this cycle
mX_readdata  out  DATA_W  read data
mX_readdatavalid  out  1  mX_readdata valid this cycle
ram_address  out  ADDR_W  to RAM address
ram_byteenable  out  BE_W  to RAM byteenable
ram_chipselect  out  1  to RAM chipselect
ram_write  out  1  to RAM write
ram_writedata  out  DATA_W  to RAM writedata
ram_clken  out  1  to RAM clken, constant 1
ram_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Clocking and reset: single clock domain on clk; reset_n is asynchronous and active-low.
- Reset state: rr_last=1 (m0 wins first contention), lock_owner=none, hold_cnt=0, rdv_pipe=0.
- Outputs during reset: both waitrequests=1, ram_chipselect=0, readdatavalid=0, readdata=0.
- Request: reqX = mX_read | mX_write.
  - Read and write both high is treated as a write.
- Grant (combinational, same cycle):
  - Lock held: only lock_owner may be granted; the other master sees waitrequest=1 even while the owner is idle.
  - No lock, one requester: that requester is granted.
  - No lock, both requesting: the master != rr_last is granted.
- Granted master: waitrequest=0, ram_chipselect=1, ram_write=mX_write, address/byteenable/writedata muxed from it.
  - Non-granted requester: waitrequest=1 and must hold its request stable.
  - No grant: ram_chipselect=0, ram_write=0.
- rr_last updates to the granted index on every grant.
- Writes complete in the grant cycle; no readdatavalid is issued.
- Reads: rdv_pipe records {valid, owner} at the grant edge.
  - Next cycle, mOwner_readdatavalid=1 and mOwner_readdata=ram_readdata.
  - The other master's readdata is 0.
  - Back-to-back reads, including alternating masters, sustain 1 per cycle.
- Lock acquire: a granted master with mX_lock=1 and lock_owner=none becomes lock_owner; hold_cnt resets to 1.
- Lock held: hold_cnt increments every cycle, saturating at HOLD_MAX.
- Lock release: when the owner samples mX_lock=0, or when hold_cnt==HOLD_MAX.
  - On release, lock_owner=none and rr_last=former owner, so a waiting other master wins next contention.
  - A timeout release forbids the owner from reacquiring the lock until the other master has been granted once or has had no request for one cycle.
- Write-then-read to the same address on consecutive cycles returns the new data; RAM is write-first on its own port.
- Reset mid-read: the pending readdatavalid is cancelled.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 5 (be=4'hF), then m0 reads addr 5 -> write waitrequest=0; m0_readdatavalid pulses exactly 1 cycle after the read grant with 0xDEADBEEF; m1 sees no valid.
- Both masters continuously read (m0 addr 1, m1 addr 2) for 6 cycles after reset -> grants m0,m1,m0,m1,m0,m1; each readdatavalid one cycle after its own grant with correct data.
- m1 writes be=4'b0100 data 0x00AB0000 to addr 7 holding 0x11223344, then reads it -> 0x11AB3344.
- m0 asserts lock with RMW on addr 9 while m1 reads continuously; m0 idle one cycle mid-lock -> m1 waitrequest=1 throughout, including the idle cycle; m1 granted the cycle after m0_lock drops.
- m0 holds lock and requests continuously, HOLD_MAX=16, m1 requesting -> lock released after 16 cycles; m1 granted next cycle; m0 cannot reacquire until after m1's grant.
- Assert reset_n=0 in the cycle after a read grant -> no readdatavalid; waitrequests=1, ram_chipselect=0 immediately (asynchronous); after release, m0 wins first contention.
